pixel_freq_array: RTL and testbench



---
 rtl/pixel_freq_array.sv | 141 ++++++++++++++
 tb/tb_pixel_freq_array.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_freq_array.sv
// pixel_freq_array
//   An array of CHANNELS pretend pixels. Each pixel turns its stored light
//   level into a square wave whose frequency rises linearly with the light
//   level. Light levels are written one channel at a time through a
//   valid/ready load port and a two-stage period pipeline. A new period is
//   picked up only when a half-period ends, so the outputs never glitch.
//
// Ports
//   CLK         system clock
//   RST         asynchronous, active-high reset
//   LOAD_VALID  load request
//   LOAD_READY  load port can accept (low while a load is in the pipeline)
//   LOAD_CH     target channel; out-of-range values are accepted and dropped
//   LOAD_LIGHT  light level
//   CH_EN       per-channel run enable
//   SEL         readout channel select
//   SYNC        phase-align strobe (only used with PIXEL_FREQ_SYNC_EN)
//   FREQ_OUT    per-channel square waves
//   SEL_OUT     FREQ_OUT[SEL], registered; 0 when SEL is out of range
//
// Build option
//   PIXEL_FREQ_SYNC_EN  when defined, SYNC reloads every enabled counter and
//                       clears its output, putting all enabled channels in
//                       phase. When undefined, SYNC is ignored.
module pixel_freq_array #(
  parameter int CLOCK_FREQ = 50_000_000,
  parameter int LOW_FREQ   = 1_000,
  parameter int HIGH_FREQ  = 5_000_000,
  parameter int INPUT_BITS = 8,
  parameter int CHANNELS   = 4,
  localparam int MAX_HALF  = CLOCK_FREQ / (2 * LOW_FREQ),
  localparam int MIN_HALF  = CLOCK_FREQ / (2 * HIGH_FREQ),
  localparam int CW        = $clog2(MAX_HALF + 1),
  localparam int SW        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  LOAD_VALID,
  output logic                  LOAD_READY,
  input  logic [SW-1:0]         LOAD_CH,
  input  logic [INPUT_BITS-1:0] LOAD_LIGHT,
  input  logic [CHANNELS-1:0]   CH_EN,
  input  logic [SW-1:0]         SEL,
  input  logic                  SYNC,
  output logic [CHANNELS-1:0]   FREQ_OUT,
  output logic                  SEL_OUT
);

  localparam int PW = CW + INPUT_BITS;
  localparam logic [CW-1:0] MAX_H   = CW'(MAX_HALF);
  localparam logic [CW-1:0] MIN_H   = CW'(MIN_HALF);
  localparam logic [CW-1:0] ONE     = CW'(1);
  localparam logic [PW-1:0] SPAN    = PW'(MAX_HALF - MIN_HALF);
  localparam logic [SW:0]   CH_LIM  = (SW + 1)'(CHANNELS);

  logic          accept;
  logic          s1_valid, s2_valid;
  logic [SW-1:0] s1_ch, s2_ch;
  logic [PW-1:0] s1_prod;
  logic          s1_full;
  logic [CW-1:0] s2_half;
  logic [CW-1:0] pending_half [CHANNELS];
  logic [CW-1:0] cnt [CHANNELS];
  logic          sync_hit;

`ifdef PIXEL_FREQ_SYNC_EN
  assign sync_hit = SYNC;
`else
  logic sync_unused;
  assign sync_unused = SYNC;
  assign sync_hit    = 1'b0;
`endif

  // One load in flight at a time: ready drops for both pipeline stages.
  assign LOAD_READY = ~(s1_valid | s2_valid);
  assign accept     = LOAD_VALID & LOAD_READY;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      s1_valid <= 1'b0;
      s1_ch    <= '0;
      s1_prod  <= '0;
      s1_full  <= 1'b0;
      s2_valid <= 1'b0;
      s2_ch    <= '0;
      s2_half  <= MAX_H;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_ch   <= LOAD_CH;
        s1_prod <= SPAN * PW'(LOAD_LIGHT);
        s1_full <= &LOAD_LIGHT;
      end
      s2_valid <= s1_valid;
      s2_ch    <= s1_ch;
      // Full-scale light is pinned to MIN_HALF; the floored formula would
      // otherwise stop one short of the top frequency.
      s2_half  <= s1_full ? MIN_H : MAX_H - CW'(s1_prod >> INPUT_BITS);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < CHANNELS; i++) pending_half[i] <= MAX_H;
    end else if (s2_valid && ({1'b0, s2_ch} < CH_LIM)) begin
      pending_half[s2_ch] <= s2_half;
    end
  end

  // Reloads read pending_half before this edge's write lands, so a value
  // written on a reload cycle waits for the following half-period.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < CHANNELS; i++) begin
        cnt[i]      <= MAX_H - ONE;
        FREQ_OUT[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (!CH_EN[i] || sync_hit) begin
          cnt[i]      <= pending_half[i] - ONE;
          FREQ_OUT[i] <= 1'b0;
        end else if (cnt[i] == '0) begin
          cnt[i]      <= pending_half[i] - ONE;
          FREQ_OUT[i] <= ~FREQ_OUT[i];
        end else begin
          cnt[i] <= cnt[i] - ONE;
        end
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      SEL_OUT <= 1'b0;
    end else begin
      SEL_OUT <= ({1'b0, SEL} < CH_LIM) ? FREQ_OUT[SEL] : 1'b0;
    end
  end

endmodule

// File: tb/tb_pixel_freq_array.sv
// Bench for pixel_freq_array with CLOCK_FREQ=1000, LOW_FREQ=10, HIGH_FREQ=250
// (MAX_HALF=50, MIN_HALF=2). A 4-channel instance carries most checks; a
// 3-channel instance exercises out-of-range LOAD_CH and SEL values.
module tb_pixel_freq_array;
  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       LOAD_VALID = 1'b0;
  logic [1:0] LOAD_CH = '0;
  logic [7:0] LOAD_LIGHT = '0;
  logic [3:0] CH_EN = 4'hF;
  logic [1:0] SEL = '0;
  logic       SYNC = 1'b0;
  logic       LOAD_READY, ready3;
  logic [3:0] fo4;
  logic [2:0] fo3;
  logic       sel_out, sel_out3;

  int vectors = 0;
  int miscompares = 0;
  int exp_pend[4];

  typedef struct { int ch; int light; int half; } vec_t;
  vec_t vecs[8];

  always #5 CLK = ~CLK;

  pixel_freq_array #(.CLOCK_FREQ(1000), .LOW_FREQ(10), .HIGH_FREQ(250),
                     .INPUT_BITS(8), .CHANNELS(4)) dut (
    .CLK(CLK), .RST(RST), .LOAD_VALID(LOAD_VALID), .LOAD_READY(LOAD_READY),
    .LOAD_CH(LOAD_CH), .LOAD_LIGHT(LOAD_LIGHT), .CH_EN(CH_EN), .SEL(SEL),
    .SYNC(SYNC), .FREQ_OUT(fo4), .SEL_OUT(sel_out));

  pixel_freq_array #(.CLOCK_FREQ(1000), .LOW_FREQ(10), .HIGH_FREQ(250),
                     .INPUT_BITS(8), .CHANNELS(3)) dut3 (
    .CLK(CLK), .RST(RST), .LOAD_VALID(LOAD_VALID), .LOAD_READY(ready3),
    .LOAD_CH(LOAD_CH), .LOAD_LIGHT(LOAD_LIGHT), .CH_EN(CH_EN[2:0]), .SEL(SEL),
    .SYNC(SYNC), .FREQ_OUT(fo3), .SEL_OUT(sel_out3));

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  function automatic logic get_out(input bit use3, input int ch);
    return use3 ? fo3[ch] : fo4[ch];
  endfunction

  // Edges until the channel output changes; -1 if it never does within limit.
  task automatic wait_toggle(input bit use3, input int ch, input int limit, output int n);
    logic prev;
    prev = get_out(use3, ch);
    n = 0;
    while (get_out(use3, ch) == prev && n < limit) begin
      step(1);
      n++;
    end
    if (get_out(use3, ch) == prev) n = -1;
  endtask

  task automatic measure_half(input bit use3, input int ch, output int len);
    int n;
    wait_toggle(use3, ch, 120, n);
    if (n < 0) len = -1;
    else wait_toggle(use3, ch, 120, len);
  endtask

  task automatic do_load(input int ch, input int light, input int half);
    int n;
    n = 0;
    while (!LOAD_READY && n < 10) begin
      step(1);
      n++;
    end
    check("ready_before_load", int'(LOAD_READY), 1);
    LOAD_VALID = 1'b1;
    LOAD_CH    = 2'(ch);
    LOAD_LIGHT = 8'(light);
    step(1);
    LOAD_VALID = 1'b0;
    step(2);
    exp_pend[ch] = half;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int len, acc;
    logic [3:0] prev4;
    logic [2:0] prev3;

    vecs = '{'{2, 0, 50}, '{0, 64, 38}, '{3, 200, 13}, '{1, 254, 3},
             '{0, 1, 50}, '{3, 16, 47}, '{1, 255, 2}, '{2, 128, 26}};
    for (int i = 0; i < 4; i++) exp_pend[i] = 50;

    // reset values
    #2 RST = 1'b1;
    step(2);
    check("rst_freq_out", int'(fo4), 0);
    check("rst_freq_out3", int'(fo3), 0);
    check("rst_sel_out", int'(sel_out), 0);
    check("rst_load_ready", int'(LOAD_READY), 1);
    RST = 1'b0;

    // free running at MAX_HALF
    wait_toggle(0, 0, 80, len);
    check("first_toggle_ch0", len, 50);
    check("all_toggle_together", int'(fo4), 15);
    for (int c = 0; c < 4; c++) begin
      measure_half(0, c, len);
      check("default_half", len, 50);
    end

    // out-of-range channel on the 3-channel instance is dropped
    do_load(3, 255, 2);
    for (int c = 0; c < 3; c++) begin
      measure_half(1, c, len);
      check("oor_load_ch3_unchanged", len, 50);
    end

    // ch1 = 128 mid half-period: current half completes at 50, then 26
    wait_toggle(0, 1, 80, len);
    step(10);
    check("ready_idle", int'(LOAD_READY), 1);
    LOAD_VALID = 1'b1; LOAD_CH = 2'd1; LOAD_LIGHT = 8'd128;
    step(1);
    LOAD_VALID = 1'b0;
    check("ready_low_s1", int'(LOAD_READY), 0);
    step(1);
    check("ready_low_s2", int'(LOAD_READY), 0);
    step(1);
    check("ready_high_again", int'(LOAD_READY), 1);
    exp_pend[1] = 26;
    wait_toggle(0, 1, 80, len);
    check("ch1_old_half_finishes", len, 37);
    wait_toggle(0, 1, 80, len);
    check("ch1_new_half", len, 26);
    measure_half(0, 0, len);
    check("ch0_unchanged", len, 50);

    // LOAD_VALID held: accepted on every 3rd cycle
    LOAD_VALID = 1'b1; LOAD_CH = 2'd2; LOAD_LIGHT = 8'd255;
    acc = 0;
    for (int i = 0; i < 9; i++) begin
      acc += int'(LOAD_READY);
      step(1);
    end
    LOAD_VALID = 1'b0;
    step(2);
    check("held_valid_accepts", acc, 3);
    exp_pend[2] = 2;
    measure_half(0, 2, len);
    check("ch2_full_light_half", len, 2);

    // table of loads
    for (int i = 0; i < 8; i++) begin
      do_load(vecs[i].ch, vecs[i].light, vecs[i].half);
      measure_half(0, vecs[i].ch, len);
      check($sformatf("vec%0d_half", i), len, vecs[i].half);
    end

    // CH_EN drop mid-period and re-raise
    for (int i = 0; i < 3 && fo4[0] != 1'b1; i++) wait_toggle(0, 0, 80, len);
    step(7);
    check("ch0_high_before_drop", int'(fo4[0]), 1);
    CH_EN[0] = 1'b0;
    step(1);
    check("en_drop_forces_0", int'(fo4[0]), 0);
    step(5);
    check("en_low_holds_0", int'(fo4[0]), 0);
    CH_EN[0] = 1'b1;
    wait_toggle(0, 0, 80, len);
    check("en_rise_first_edge", len, exp_pend[0]);
    check("en_rise_edge_is_rising", int'(fo4[0]), 1);
    CH_EN[0] = 1'b0;
    do_load(0, 128, 26);
    step(2);
    CH_EN[0] = 1'b1;
    wait_toggle(0, 0, 80, len);
    check("en_rise_after_load", len, 26);

    // readout select
    for (int s = 0; s < 4; s++) begin
      SEL = 2'(s);
      for (int r = 0; r < 4; r++) begin
        prev4 = fo4;
        prev3 = fo3;
        step(1);
        check($sformatf("sel_out_%0d", s), int'(sel_out), int'(prev4[s]));
        if (s < 3) check($sformatf("sel_out3_%0d", s), int'(sel_out3), int'(prev3[s]));
        else       check("sel_out3_oor", int'(sel_out3), 0);
      end
    end

    // SYNC: all channels loaded to 26 but out of phase
    for (int c = 0; c < 4; c++) do_load(c, 128, 26);
    step(60);
    wait_toggle(0, 0, 80, len);
    step(5);
    SYNC = 1'b1;
    step(1);
    SYNC = 1'b0;
`ifdef PIXEL_FREQ_SYNC_EN
    check("sync_clears", int'(fo4), 0);
    step(25);
    check("sync_hold", int'(fo4), 0);
    step(1);
    check("sync_aligned_rise", int'(fo4), 15);
    step(26);
    check("sync_aligned_fall", int'(fo4), 0);
`else
    wait_toggle(0, 0, 80, len);
    check("sync_ignored", len, 20);
`endif

    // reset in the middle of a load
    for (int i = 0; i < 10 && !LOAD_READY; i++) step(1);
    LOAD_VALID = 1'b1; LOAD_CH = 2'd1; LOAD_LIGHT = 8'd255;
    step(1);
    LOAD_VALID = 1'b0;
    #2 RST = 1'b1;
    #1;
    check("midload_rst_freq_out", int'(fo4), 0);
    check("midload_rst_sel_out", int'(sel_out), 0);
    check("midload_rst_ready", int'(LOAD_READY), 1);
    step(2);
    RST = 1'b0;
    wait_toggle(0, 1, 80, len);
    check("midload_first_half", len, 50);
    wait_toggle(0, 1, 80, len);
    check("midload_no_write", len, 50);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
